stage_4_mem: RTL and testbench
==============================

# stage_4_mem

Memory-access stage of the 5-stage RV32I pipeline, between execute and write-back (`stage_5`). It accepts one instruction per handshake from execute and performs loads and stores on a single-port data memory with a req/ack handshake. It aligns and sign-extends load data, then registers the result into the MEM/WB outputs that `stage_5` consumes directly. It stalls upstream while a memory transaction is outstanding.

## Interface
- No parameters; all data/address widths fixed at 32.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: execute presents an instruction.
- `o_ready` out 1: stage accepts; transfer when `i_valid & o_ready` at rising edge.
- `i_counter` in 32: PC of instruction.
- `i_alu_out` in 32: ALU result / effective address.
- `i_rs2` in 32: store data.
- `i_rd_num` in 5: destination register.
- `i_mem_op` in 2: 00 none, 01 load, 10 store, 11 treated as none.
- `i_funct3` in 3: RV32I load/store size/sign code.
- `dmem_req` out 1; `dmem_we` out 1; `dmem_addr` out 32 (word-aligned); `dmem_wdata` out 32; `dmem_be` out 4.
- `dmem_ack` in 1; `dmem_rdata` in 32: word read data, valid with ack.
- `o_valid` out 1: MEM/WB holds a retiring instruction this cycle.
- `o_counter`, `o_alu_out`, `o_mem_out` out 32 each; `o_rd_num` out 5; `o_op_type` out 1 (1 = select `o_mem_out`).
- `o_exc` out 1: one-cycle pulse for a misaligned or illegal-size access.

## Operation
- FSM states: IDLE, WAIT. `o_ready = (state == IDLE)`. `i_valid` is ignored in WAIT; upstream holds its inputs.
- **IDLE, accept, op none:**
  - Next cycle: `o_valid = 1`, `o_alu_out = i_alu_out`, `o_rd_num = i_rd_num`, `o_op_type = 0`.
  - State stays IDLE.
- **IDLE, accept, load or store, legal and aligned:**
  - Latch address, funct3, rs2, rd, and PC.
  - Go to WAIT.
- **Illegal access** (half with addr[0]=1; word with addr[1:0]≠0; load funct3 ∈ {3,6,7}; store funct3 > 2):
  - No dmem request is issued.
  - Next cycle: `o_valid = 1`, `o_exc = 1`, `o_rd_num = 0`.
- **WAIT:**
  - `dmem_req = 1`, `dmem_addr = {addr[31:2], 2'b00}`, `dmem_we = 1` for store.
  - When `dmem_ack` is sampled high, MEM/WB is captured and the state returns to IDLE.
- **Load result:**
  - LB/LBU: byte lane `addr[1:0]`, sign- or zero-extended.
  - LH/LHU: halfword `addr[1]`, sign- or zero-extended.
  - LW: whole word.
  - `o_op_type = 1`, `o_rd_num` = latched rd.
- **Store:**
  - SB: `wdata = {4{rs2[7:0]}}`, `be = 4'b0001 << addr[1:0]`.
  - SH: `wdata = {2{rs2[15:0]}}`, `be = addr[1] ? 4'b1100 : 4'b0011`.
  - SW: `wdata = rs2`, `be = 4'b1111`.
  - Retire with `o_rd_num = 0` and `o_op_type = 0`.
- **Bubbles:** in any cycle with `o_valid = 0`, `o_rd_num = 0`, so the combinational write-back writes x0 only. Other data outputs hold their last value.
- `o_alu_out` always carries the latched ALU result/address; `o_counter` carries the PC.

## Timing
- **Reset:** state IDLE; all outputs 0 (`o_ready` = 1 combinationally from IDLE); dmem outputs 0.
- **Non-memory latency:** accepted at edge N, `o_valid` in cycle N+1. Throughput 1/cycle.
- **Memory latency:**
  - Accepted at edge N; `dmem_req` high from cycle N+1.
  - Ack in cycle N+k (k ≥ 1) gives `o_valid` in cycle N+k+1, which is also the cycle `o_ready` returns to 1.
  - Minimum 2 cycles; at most one memory op per 2 cycles.
- `dmem_req` and all dmem outputs stay stable from WAIT entry until the ack cycle inclusive. Req is low in the cycle after ack.
- `dmem_ack` while not in WAIT is ignored.
- **`rst` while in WAIT:** next cycle `dmem_req = 0`, state IDLE, `o_valid = 0`. The in-flight instruction is dropped and a later ack is ignored.
- `o_valid` and `o_exc` are single-cycle pulses per instruction.

## Structure
- Shared constants header (existing constants header):
  - `MEM_OP_NONE/LOAD/STORE` encodings.
  - funct3 codes `F3_B/H/W/BU/HU`.
  - FSM state encodings `S_IDLE/S_WAIT`.
- One combinational sub-module, `load_extend`: inputs `rdata[31:0]`, `addr_lo[1:0]`, `funct3[2:0]`; output `data[31:0]`.
- Store-lane generation stays inline.

## Test plan
- **Non-memory instruction:** `i_mem_op = 0`, `i_alu_out = 0x1234`, rd = 5 → next cycle `o_valid = 1`, `o_alu_out = 0x1234`, `o_rd_num = 5`, `o_op_type = 0`; `dmem_req` never asserted.
- **LB:** at 0x1003, `dmem_rdata = 0x80000000`, ack in first WAIT cycle → `dmem_addr = 0x1000`, `o_mem_out = 0xFFFFFF80`, `o_op_type = 1`, `o_valid` 2 cycles after accept. Same with LBU → `0x00000080`.
- **SH:** at 0x2002, `rs2 = 0xABCD1234` → `dmem_we = 1`, `wdata = 0x12341234`, `be = 4'b1100`; retire with `o_rd_num = 0`.
- **Misaligned LW:** at 0x3001 → no `dmem_req`, next cycle `o_exc = 1`, `o_valid = 1`, `o_rd_num = 0`.
- **Delayed ack:** ack 3 cycles after req → req held 3 cycles with stable addr/be, `o_ready = 0` throughout, held upstream instruction accepted only after return to IDLE.
- **Reset during WAIT:** `rst` pulsed in WAIT → next cycle `dmem_req = 0`, `o_valid = 0`, `o_ready = 1`; a subsequent stray ack produces no `o_valid`.

Source files
------------

// File: rtl/stage_4_mem_pkg.sv
// Shared constants for the memory-access stage: op and funct3 encodings,
// FSM states and the access-legality rule shared by the datapath.
package stage_4_mem_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // funct3[1:0] is the access size (byte/half/word) for every legal code.
  function automatic logic access_illegal(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic bad_code;
    logic misaligned;
    if (is_store) bad_code = (funct3 > F3_W);
    else          bad_code = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return bad_code || misaligned;
  endfunction

endpackage

// File: rtl/stage_4_mem_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
interface stage_4_mem_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it according to the RV32I load funct3.
module load_extend
  import stage_4_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'd0, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'd0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/stage_4_mem.sv
// RV32I memory-access stage: issues loads/stores on a req/ack data memory,
// aligns load data and registers the MEM/WB outputs consumed by write-back.
module stage_4_mem
  import stage_4_mem_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  // Upstream handshake: a transfer happens on a rising edge where
  // i_valid & o_ready; o_ready is high only in IDLE, so i_valid is ignored
  // while a memory access is outstanding and upstream must hold its inputs.
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [31:0]  i_counter,
  input  logic [31:0]  i_alu_out,
  input  logic [31:0]  i_rs2,
  input  logic [4:0]   i_rd_num,
  input  logic [1:0]   i_mem_op,
  input  logic [2:0]   i_funct3,
  stage_4_mem_if.master dmem,
  output logic         o_valid,
  output logic [31:0]  o_counter,
  output logic [31:0]  o_alu_out,
  output logic [31:0]  o_mem_out,
  output logic [4:0]   o_rd_num,
  output logic         o_op_type,
  output logic         o_exc,
  output state_t       o_dbg_state
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc_q, pc_d;
  logic        is_store_q, is_store_d;

  logic        o_valid_q, o_valid_d;
  logic [31:0] o_counter_q, o_counter_d;
  logic [31:0] o_alu_out_q, o_alu_out_d;
  logic [31:0] o_mem_out_q, o_mem_out_d;
  logic [4:0]  o_rd_num_q, o_rd_num_d;
  logic        o_op_type_q, o_op_type_d;
  logic        o_exc_q, o_exc_d;

  logic        is_mem;
  logic [31:0] load_data;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;

  load_extend u_load_extend (
    .rdata   (dmem.dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    pc_d        = pc_q;
    is_store_d  = is_store_q;
    o_counter_d = o_counter_q;
    o_alu_out_d = o_alu_out_q;
    o_mem_out_d = o_mem_out_q;
    o_op_type_d = o_op_type_q;
    // Bubbles retire nothing and steer write-back to x0.
    o_valid_d   = 1'b0;
    o_rd_num_d  = 5'd0;
    o_exc_d     = 1'b0;
    is_mem      = (i_mem_op == MEM_OP_LOAD) || (i_mem_op == MEM_OP_STORE);

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (!is_mem) begin
            o_valid_d   = 1'b1;
            o_counter_d = i_counter;
            o_alu_out_d = i_alu_out;
            o_rd_num_d  = i_rd_num;
            o_op_type_d = 1'b0;
          end else if (access_illegal(i_mem_op == MEM_OP_STORE, i_funct3, i_alu_out[1:0])) begin
            o_valid_d   = 1'b1;
            o_exc_d     = 1'b1;
            o_counter_d = i_counter;
            o_alu_out_d = i_alu_out;
            o_op_type_d = 1'b0;
          end else begin
            addr_d     = i_alu_out;
            funct3_d   = i_funct3;
            rs2_d      = i_rs2;
            rd_d       = i_rd_num;
            pc_d       = i_counter;
            is_store_d = (i_mem_op == MEM_OP_STORE);
            state_d    = S_WAIT;
          end
        end
      end
      default: begin
        if (dmem.dmem_ack) begin
          o_valid_d   = 1'b1;
          o_counter_d = pc_q;
          o_alu_out_d = addr_q;
          if (is_store_q) begin
            o_op_type_d = 1'b0;
          end else begin
            o_mem_out_d = load_data;
            o_rd_num_d  = rd_q;
            o_op_type_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Byte lanes are derived from latched values, so they cannot move during WAIT.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        lane_wdata = {4{rs2_q[7:0]}};
        lane_be    = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        lane_wdata = {2{rs2_q[15:0]}};
        lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_wdata = rs2_q;
        lane_be    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      funct3_q    <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
      is_store_q  <= 1'b0;
      o_valid_q   <= 1'b0;
      o_counter_q <= '0;
      o_alu_out_q <= '0;
      o_mem_out_q <= '0;
      o_rd_num_q  <= '0;
      o_op_type_q <= 1'b0;
      o_exc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      pc_q        <= pc_d;
      is_store_q  <= is_store_d;
      o_valid_q   <= o_valid_d;
      o_counter_q <= o_counter_d;
      o_alu_out_q <= o_alu_out_d;
      o_mem_out_q <= o_mem_out_d;
      o_rd_num_q  <= o_rd_num_d;
      o_op_type_q <= o_op_type_d;
      o_exc_q     <= o_exc_d;
    end
  end

  assign o_ready         = (state_q == S_IDLE);
  assign dmem.dmem_req   = (state_q == S_WAIT);
  assign dmem.dmem_we    = (state_q == S_WAIT) && is_store_q;
  assign dmem.dmem_addr  = (state_q == S_WAIT) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dmem.dmem_wdata = (state_q == S_WAIT) ? lane_wdata : 32'd0;
  assign dmem.dmem_be    = (state_q == S_WAIT) ? lane_be : 4'd0;

  assign o_valid     = o_valid_q;
  assign o_counter   = o_counter_q;
  assign o_alu_out   = o_alu_out_q;
  assign o_mem_out   = o_mem_out_q;
  assign o_rd_num    = o_rd_num_q;
  assign o_op_type   = o_op_type_q;
  assign o_exc       = o_exc_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_stage_4_mem.sv
// Bench for stage_4_mem: directed vector table, hand sequences for ack delay
// and reset-in-WAIT, and random traffic against a behavioural access model.
module tb_stage_4_mem;
  import stage_4_mem_pkg::*;

  typedef struct {
    logic [1:0]  mem_op;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          delay;
  } stim_t;

  typedef struct {
    logic        mem;
    logic        exc;
    logic        we;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] mem_out;
    logic [4:0]  rd;
    logic        op_type;
  } resp_t;

  typedef struct {
    stim_t s;
    resp_t r;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_counter = '0, i_alu_out = '0, i_rs2 = '0;
  logic [4:0]  i_rd_num = '0;
  logic [1:0]  i_mem_op = '0;
  logic [2:0]  i_funct3 = '0;
  logic        o_valid, o_op_type, o_exc;
  logic [31:0] o_counter, o_alu_out, o_mem_out;
  logic [4:0]  o_rd_num;
  state_t      dbg_state;

  always #5 clk = ~clk;

  stage_4_mem_if dmem_bus ();

  stage_4_mem dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_counter   (i_counter),
    .i_alu_out   (i_alu_out),
    .i_rs2       (i_rs2),
    .i_rd_num    (i_rd_num),
    .i_mem_op    (i_mem_op),
    .i_funct3    (i_funct3),
    .dmem        (dmem_bus),
    .o_valid     (o_valid),
    .o_counter   (o_counter),
    .o_alu_out   (o_alu_out),
    .o_mem_out   (o_mem_out),
    .o_rd_num    (o_rd_num),
    .o_op_type   (o_op_type),
    .o_exc       (o_exc),
    .o_dbg_state (dbg_state)
  );

  initial begin
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = '0;
  end

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q[$];
  logic [31:0]  last_mem_out = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("stray_valid", {127'd0, o_valid}, 128'd0);
        else chk("retire", {25'd0, o_counter, o_alu_out, o_mem_out, o_rd_num, o_op_type, o_exc},
                 exp_q.pop_front());
      end else begin
        chk("bubble", {122'd0, o_valid, o_rd_num, o_exc}, 128'd0);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic resp_t model(input stim_t s);
    resp_t       r;
    int          nbytes;
    bit          is_ld, is_st, code_ok;
    logic [31:0] v, mask;
    r = '{default: '0};
    is_ld   = (s.mem_op == 2'b01);
    is_st   = (s.mem_op == 2'b10);
    nbytes  = 1 << s.f3[1:0];
    code_ok = is_ld ? (s.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (s.f3 <= 3'd2);
    if (!is_ld && !is_st) begin
      r.rd = s.rd;
      return r;
    end
    if (!code_ok || (s.addr % 32'(nbytes)) != 0) begin
      r.exc = 1'b1;
      return r;
    end
    r.mem   = 1'b1;
    r.we    = is_st;
    r.daddr = s.addr & 32'hFFFF_FFFC;
    if (is_st) begin
      r.be = 4'(((1 << nbytes) - 1) << s.addr[1:0]);
      for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = s.rs2[8*(i % nbytes) +: 8];
    end else begin
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      v = (s.rdata >> (8 * s.addr[1:0])) & mask;
      if (!s.f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
      r.mem_out = v;
      r.rd      = s.rd;
      r.op_type = 1'b1;
    end
    return r;
  endfunction

  function automatic stim_t st(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] rs2, input logic [31:0] rdata, input logic [4:0] rd,
                               input int delay);
    stim_t s;
    s = '{mem_op: op, f3: f3, pc: 32'd0, addr: addr, rs2: rs2, rdata: rdata, rd: rd, delay: delay};
    return s;
  endfunction

  function automatic resp_t rs(input logic mem, input logic exc, input logic we, input logic [31:0] daddr,
                               input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] mem_out,
                               input logic [4:0] rd, input logic op_type);
    resp_t r;
    r = '{mem: mem, exc: exc, we: we, daddr: daddr, wdata: wdata, be: be, mem_out: mem_out,
          rd: rd, op_type: op_type};
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input stim_t s);
    i_counter = s.pc;
    i_alu_out = s.addr;
    i_rs2     = s.rs2;
    i_rd_num  = s.rd;
    i_mem_op  = s.mem_op;
    i_funct3  = s.f3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    dmem_bus.dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    last_mem_out = '0;
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic apply(input stim_t s, input resp_t r, input bit has_nxt, input stim_t nxt);
    int          guard;
    logic [31:0] mo;
    guard = 0;
    while (o_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (o_ready !== 1'b1) begin
      chk("ready_timeout", {127'd0, o_ready}, 128'd1);
      return;
    end
    drive(s);
    i_valid = 1'b1;
    mo = r.op_type ? r.mem_out : last_mem_out;
    last_mem_out = mo;
    exp_q.push_back({25'd0, s.pc, s.addr, mo, r.rd, r.op_type, r.exc});
    @(posedge clk); #1;
    if (has_nxt) drive(nxt);
    i_valid = has_nxt;
    if (!r.mem) begin
      chk("nomem_req", {127'd0, dmem_bus.dmem_req}, 128'd0);
      chk("nomem_latency", {126'd0, o_valid, o_ready}, 128'd3);
    end else begin
      for (int c = 1; c <= s.delay; c++) begin
        chk("wait_ctl", {125'd0, dmem_bus.dmem_req, o_ready, o_valid}, 128'd4);
        chk("wait_addr", {96'd0, dmem_bus.dmem_addr}, {96'd0, r.daddr});
        chk("wait_we", {127'd0, dmem_bus.dmem_we}, {127'd0, r.we});
        if (r.we) chk("wait_wdata_be", {92'd0, dmem_bus.dmem_wdata, dmem_bus.dmem_be}, {92'd0, r.wdata, r.be});
        if (c == s.delay) begin
          dmem_bus.dmem_ack   = 1'b1;
          dmem_bus.dmem_rdata = s.rdata;
        end else begin
          dmem_bus.dmem_rdata = $urandom();
        end
        @(posedge clk); #1;
      end
      dmem_bus.dmem_ack   = 1'b0;
      dmem_bus.dmem_rdata = $urandom();
      chk("retire_timing", {125'd0, o_valid, o_ready, dmem_bus.dmem_req}, 128'd6);
    end
  endtask

  // ---------------- test ----------------
  vec_t  vecs[15];
  stim_t s, nxt;
  resp_t r;

  initial begin
    vecs[0]  = '{st(2'b00, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1),
                 rs(0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 5'd5, 0)};
    vecs[1]  = '{st(2'b01, F3_B, 32'h0000_1003, 32'h0, 32'h8000_0000, 5'd3, 1),
                 rs(1, 0, 0, 32'h1000, 32'h0, 4'h0, 32'hFFFF_FF80, 5'd3, 1)};
    vecs[2]  = '{st(2'b01, F3_BU, 32'h0000_1003, 32'h0, 32'h8000_0000, 5'd3, 1),
                 rs(1, 0, 0, 32'h1000, 32'h0, 4'h0, 32'h0000_0080, 5'd3, 1)};
    vecs[3]  = '{st(2'b10, F3_H, 32'h0000_2002, 32'hABCD_1234, 32'h0, 5'd9, 1),
                 rs(1, 0, 1, 32'h2000, 32'h1234_1234, 4'b1100, 32'h0, 5'd0, 0)};
    vecs[4]  = '{st(2'b01, F3_W, 32'h0000_3001, 32'h0, 32'h0, 5'd8, 1),
                 rs(0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 5'd0, 0)};
    vecs[5]  = '{st(2'b10, F3_B, 32'h0000_1001, 32'h0000_00EF, 32'h0, 5'd2, 2),
                 rs(1, 0, 1, 32'h1000, 32'hEFEF_EFEF, 4'b0010, 32'h0, 5'd0, 0)};
    vecs[6]  = '{st(2'b01, F3_H, 32'h0000_1002, 32'h0, 32'h8001_7FFF, 5'd4, 1),
                 rs(1, 0, 0, 32'h1000, 32'h0, 4'h0, 32'hFFFF_8001, 5'd4, 1)};
    vecs[7]  = '{st(2'b01, F3_HU, 32'h0000_1000, 32'h0, 32'h8001_7FFF, 5'd4, 2),
                 rs(1, 0, 0, 32'h1000, 32'h0, 4'h0, 32'h0000_7FFF, 5'd4, 1)};
    vecs[8]  = '{st(2'b10, F3_W, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0, 5'd1, 1),
                 rs(1, 0, 1, 32'h2004, 32'hDEAD_BEEF, 4'b1111, 32'h0, 5'd0, 0)};
    vecs[9]  = '{st(2'b01, 3'd3, 32'h0000_0100, 32'h0, 32'h0, 5'd7, 1),
                 rs(0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 5'd0, 0)};
    vecs[10] = '{st(2'b10, 3'd4, 32'h0000_0100, 32'h0, 32'h0, 5'd7, 1),
                 rs(0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 5'd0, 0)};
    vecs[11] = '{st(2'b11, F3_W, 32'h0000_0055, 32'h0, 32'h0, 5'd6, 1),
                 rs(0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 5'd6, 0)};
    vecs[12] = '{st(2'b01, F3_W, 32'h0000_4008, 32'h0, 32'h0BAD_F00D, 5'd12, 3),
                 rs(1, 0, 0, 32'h4008, 32'h0, 4'h0, 32'h0BAD_F00D, 5'd12, 1)};
    vecs[13] = '{st(2'b10, F3_H, 32'h0000_2003, 32'h0, 32'h0, 5'd9, 1),
                 rs(0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 5'd0, 0)};
    vecs[14] = '{st(2'b01, F3_B, 32'h0000_1001, 32'h0, 32'h0000_7F00, 5'd13, 4),
                 rs(1, 0, 0, 32'h1000, 32'h0, 4'h0, 32'h0000_007F, 5'd13, 1)};

    do_reset();
    chk("rst_state", {127'd0, dbg_state}, {127'd0, S_IDLE});
    chk("rst_ctl", {125'd0, o_ready, o_valid, dmem_bus.dmem_req}, 128'd4);
    chk("rst_dmem", {59'd0, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wdata, dmem_bus.dmem_be}, 128'd0);
    chk("rst_out", {25'd0, o_counter, o_alu_out, o_mem_out, o_rd_num, o_op_type, o_exc}, 128'd0);

    nxt = st(2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1);
    for (int i = 0; i < 15; i++) begin
      s = vecs[i].s;
      s.pc = 32'h100 + 32'(4 * i);
      apply(s, vecs[i].r, 1'b0, nxt);
    end

    // Delayed ack with the next instruction already waiting upstream.
    s   = st(2'b10, F3_B, 32'h0000_6002, 32'h0000_005A, 32'h0, 5'd10, 3);
    s.pc = 32'h200;
    nxt = st(2'b00, 3'd0, 32'h0000_0777, 32'h0, 32'h0, 5'd11, 1);
    nxt.pc = 32'h204;
    apply(s, rs(1, 0, 1, 32'h6000, 32'h5A5A_5A5A, 4'b0100, 32'h0, 5'd0, 0), 1'b1, nxt);
    apply(nxt, model(nxt), 1'b0, nxt);

    // Reset while a load is outstanding; a later ack must be ignored.
    s = st(2'b01, F3_W, 32'h0000_5000, 32'h0, 32'h1111_2222, 5'd14, 1);
    drive(s);
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("rstw_req", {127'd0, dmem_bus.dmem_req}, 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_mem_out = '0;
    chk("rstw_after", {125'd0, dmem_bus.dmem_req, o_valid, o_ready}, 128'd1);
    dmem_bus.dmem_ack = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("stray_ack", {126'd0, o_valid, dmem_bus.dmem_req}, 128'd0);
    end
    dmem_bus.dmem_ack = 1'b0;

    for (int i = 0; i < 40; i++) begin
      s = st(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom(), $urandom(), $urandom(),
             5'($urandom_range(0, 31)), $urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) s.addr[1:0] = 2'b00;
      s.pc = $urandom();
      apply(s, model(s), 1'b0, nxt);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
